audio_nco_clkgen: RTL and testbench

//  Multi-channel fractional clock generator (NCO) for the audio subsystem, clocked by the 50 MHz refclk.

---
 rtl/audio_nco_clkgen.sv | 118 +++++++++++
 tb/tb_audio_nco_clkgen.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/audio_nco_clkgen.sv
// Multi-channel phase-accumulator clock generator with carry-aligned
// retuning and a global PLL-style lock indicator.
module audio_nco_clkgen #(
    parameter int               NUM_CH      = 2,
    parameter int               ACC_W       = 32,
    parameter logic [ACC_W-1:0] DEF_INC     = 2111062325,
    parameter int               LOCK_CYCLES = 1024,
    parameter int               CH_W        = 3
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    output logic [NUM_CH-1:0] outclk,
    output logic [NUM_CH-1:0] tick,
    output logic              locked
);

    localparam int               CNT_W    = $clog2(LOCK_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [ACC_W-1:0] MAX_INC  = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [CH_W:0]    NCH      = (CH_W+1)'(NUM_CH);

    localparam logic [0:0] ST_SETTLE = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic              w_valid_wr;
    logic [ACC_W-1:0]  w_cfg_inc;
    logic [NUM_CH-1:0] w_pend;

    assign w_valid_wr = cfg_wr && ({1'b0, cfg_ch} < NCH);
    // Half-scale cap keeps outclk at or below refclk/4.
    assign w_cfg_inc  = (cfg_inc > MAX_INC) ? MAX_INC : cfg_inc;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [ACC_W-1:0] r_acc;
        logic [ACC_W-1:0] r_inc;
        logic [ACC_W-1:0] r_shadow;
        logic             r_pend;
        logic             r_out;
        logic             r_tick;
        logic [ACC_W:0]   w_sum;
        logic             w_carry;
        logic             w_wr;
        logic             w_zero_apply;

        assign w_sum        = {1'b0, r_acc} + {1'b0, r_inc};
        assign w_carry      = w_sum[ACC_W];
        assign w_wr         = w_valid_wr && (cfg_ch == CH_W'(i));
        assign w_zero_apply = r_pend && ((r_inc == '0) || (r_shadow == '0));

        always_ff @(posedge refclk) begin
            if (rst) begin
                r_acc    <= '0;
                r_inc    <= DEF_INC;
                r_shadow <= DEF_INC;
                r_pend   <= 1'b0;
                r_out    <= 1'b0;
                r_tick   <= 1'b0;
            end else begin
                if (w_zero_apply) begin
                    r_inc  <= r_shadow;
                    r_acc  <= '0;
                    r_out  <= 1'b0;
                    r_tick <= 1'b0;
                    r_pend <= 1'b0;
                end else if (r_inc == '0) begin
                    r_out  <= 1'b0;
                    r_tick <= 1'b0;
                end else begin
                    r_acc  <= w_sum[ACC_W-1:0];
                    r_tick <= w_carry;
                    r_out  <= r_out ^ w_carry;
                    // Retune only on a carry so no runt phase appears.
                    if (r_pend && w_carry) begin
                        r_inc  <= r_shadow;
                        r_pend <= 1'b0;
                    end
                end
                if (w_wr) begin
                    r_shadow <= w_cfg_inc;
                    r_pend   <= 1'b1;
                end
            end
        end

        assign outclk[i] = r_out;
        assign tick[i]   = r_tick;
        assign w_pend[i] = r_pend;
    end

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge refclk) begin
        if (rst) begin
            r_state <= ST_SETTLE;
            r_cnt   <= '0;
        end else if (r_state == ST_LOCKED) begin
            if (w_valid_wr) begin
                r_state <= ST_SETTLE;
                r_cnt   <= '0;
            end
        end else begin
            if (w_valid_wr || (|w_pend)) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_state <= ST_LOCKED;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign locked = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_audio_nco_clkgen.sv
// Directed bench for audio_nco_clkgen: lock timing, retune on carry,
// disable/restart, invalid channel, clamp and reset mid-settle.
module tb_audio_nco_clkgen;

    localparam logic [31:0] DEF = 32'd2111062325;
    localparam logic [31:0] NEW = 32'd1939538511;

    logic        refclk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_wr = 1'b0;
    logic [2:0]  cfg_ch = '0;
    logic [31:0] cfg_inc = '0;
    logic [1:0]  outclk;
    logic [1:0]  tick;
    logic        locked;

    audio_nco_clkgen #(
        .NUM_CH(2), .ACC_W(32), .DEF_INC(DEF),
        .LOCK_CYCLES(1024), .CH_W(3)
    ) dut (
        .refclk(refclk), .rst(rst), .cfg_wr(cfg_wr),
        .cfg_ch(cfg_ch), .cfg_inc(cfg_inc),
        .outclk(outclk), .tick(tick), .locked(locked)
    );

    always #5 refclk = ~refclk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int tcnt[2], dbl[2], rmin[2], rmax[2], rlen[2];
    int lowcnt;
    bit seen[2];
    logic [1:0] po, pt;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clr_stats();
        for (int i = 0; i < 2; i++) begin
            tcnt[i] = 0; dbl[i] = 0; rmin[i] = 99;
            rmax[i] = 0; rlen[i] = 0; seen[i] = 0;
        end
        lowcnt = 0; po = outclk; pt = tick;
    endtask

    task automatic step();
        @(posedge refclk);
        #1;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (tick[i]) begin
                tcnt[i]++;
                if (pt[i]) dbl[i]++;
            end
            if (outclk[i] != po[i]) begin
                if (seen[i]) begin
                    if (rlen[i] < rmin[i]) rmin[i] = rlen[i];
                    if (rlen[i] > rmax[i]) rmax[i] = rlen[i];
                end
                seen[i] = 1;
                rlen[i] = 1;
            end else begin
                rlen[i]++;
            end
        end
        if (!locked) lowcnt++;
        po = outclk; pt = tick;
    endtask

    task automatic wait_tick(input int ch, output int at);
        int k;
        k = 0;
        do begin
            step(); k++;
        end while (!tick[ch] && k < 40);
        check("wait_tick", tick[ch], 1);
        at = cyc;
    endtask

    task automatic wr(input logic [2:0] ch, input logic [31:0] v);
        cfg_wr = 1'b1; cfg_ch = ch; cfg_inc = v;
        step();
        cfg_wr = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, a2, a5, a6, k;
        // reset
        step(); step();
        check("rst_outclk", outclk, 0);
        check("rst_tick", tick, 0);
        check("rst_locked", locked, 0);

        // 1: default tone and lock timing
        rst = 1'b0; cyc = 0; clr_stats();
        step(); check("t1_tick_e1", tick, 0);
        step(); check("t1_tick_e2", tick, 0);
        step(); check("t1_tick_e3", tick, 2'b11);
        check("t1_oc_e3", outclk, 2'b11);
        while (cyc < 1023) step();
        check("t1_lock_1023", locked, 0);
        step();
        check("t1_lock_1024", locked, 1);
        check("t1_ticks0", tcnt[0], 503);
        check("t1_ticks1", tcnt[1], 503);
        check("t1_rmin0", rmin[0], 2);
        check("t1_rmax0", rmax[0], 3);

        // 2: retune ch1 while locked
        clr_stats();
        wr(3'd1, NEW);
        check("t2_unlock", locked, 0);
        wait_tick(1, a);
        while (cyc < a + 1023) step();
        check("t2_lock_m1", locked, 0);
        step();
        check("t2_relock", locked, 1);
        check("t2_rmin1_ok", rmin[1] >= 2, 1);
        check("t2_rmin0", rmin[0], 2);
        check("t2_rmax0", rmax[0], 3);
        clr_stats();
        repeat (1024) step();
        check("t2_rate1", (tcnt[1] == 462) || (tcnt[1] == 463), 1);
        check("t2_rate0", (tcnt[0] == 503) || (tcnt[0] == 504), 1);
        check("t2_rmin1", rmin[1], 2);
        check("t2_rmax1", rmax[1], 3);

        // 3: disable ch0, then restart from zero phase
        wr(3'd0, 32'd0);
        step();
        check("t3_off_oc", outclk[0], 0);
        check("t3_off_tick", tick[0], 0);
        clr_stats();
        repeat (20) step();
        check("t3_off_ticks", tcnt[0], 0);
        check("t3_off_oc2", outclk[0], 0);
        wr(3'd0, DEF);
        step(); a2 = cyc;
        check("t3_apply_tick", tick[0], 0);
        step(); check("t3_a1", tick[0], 0);
        step(); check("t3_a2", tick[0], 0);
        step(); check("t3_a3", tick[0], 1);
        check("t3_a3_oc", outclk[0], 1);
        k = 0;
        while (!locked && k < 1100) begin step(); k++; end
        check("t3_relock", cyc - a2, 1024);

        // 4: out-of-range channel is ignored
        clr_stats();
        wr(3'd5, 32'd123);
        check("t4_locked", locked, 1);
        repeat (1023) step();
        check("t4_lowcnt", lowcnt, 0);
        check("t4_rate0", (tcnt[0] == 503) || (tcnt[0] == 504), 1);
        check("t4_rate1", (tcnt[1] == 462) || (tcnt[1] == 463), 1);

        // 5: clamp to half scale
        wr(3'd0, 32'hFFFF_FFFF);
        wait_tick(0, a5);
        clr_stats();
        repeat (40) step();
        check("t5_ticks", tcnt[0], 20);
        check("t5_dbl", dbl[0], 0);
        check("t5_rmin", rmin[0], 2);
        check("t5_rmax", rmax[0], 2);

        // 6: write mid-settle, then reset mid-settle with a write pending
        while (cyc < a5 + 500) step();
        wr(3'd1, DEF);
        wait_tick(1, a6);
        while (cyc < a6 + 1023) step();
        check("t6_lock_m1", locked, 0);
        step();
        check("t6_lock", locked, 1);
        repeat (5) step();
        wr(3'd1, NEW);
        check("t6_settle", locked, 0);
        rst = 1'b1;
        step();
        check("t6_rst_oc", outclk, 0);
        check("t6_rst_tick", tick, 0);
        check("t6_rst_lock", locked, 0);
        rst = 1'b0; cyc = 0; clr_stats();
        step(); step(); step();
        check("t6_tick_e3", tick, 2'b11);
        while (cyc < 1023) step();
        check("t6_lock_1023", locked, 0);
        step();
        check("t6_lock_1024", locked, 1);
        check("t6_ticks0", tcnt[0], 503);
        check("t6_ticks1", tcnt[1], 503);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
